// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the iterative ALU.
//   - opcode encodings (OP_*)
//   - control FSM state encoding (state_t)
//   - bit positions inside the {N,Z,V,C} flag register (FN/FZ/FV/FC)
//   - shifter kind encodings (SH_*), equal to op[1:0] of the shift opcodes
package alu_pkg;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0010;
   localparam logic [3:0] OP_OR  = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_ADC = 4'b0101;
   localparam logic [3:0] OP_SBC = 4'b0110;
   localparam logic [3:0] OP_LSL = 4'b1000;
   localparam logic [3:0] OP_LSR = 4'b1001;
   localparam logic [3:0] OP_ASR = 4'b1010;
   localparam logic [3:0] OP_MUL = 4'b1011;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int FN = 3;
   localparam int FZ = 2;
   localparam int FV = 1;
   localparam int FC = 0;

   localparam logic [1:0] SH_LSL = 2'b00;
   localparam logic [1:0] SH_LSR = 2'b01;
   localparam logic [1:0] SH_ASR = 2'b10;

endpackage

// File: rtl/alu_iter_shift.sv
// alu_iter_shift: iterative one-bit-per-clock shifter with sticky carry.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   load        capture a, kind and the clamped amount min(b, WIDTH)
//   step        perform one shift step
//   kind        SH_LSL / SH_LSR / SH_ASR
//   a, b        operand and unsigned shift amount
//   zero_amt    b == 0 (combinational, used by the controller at accept)
//   last        the step taken this cycle is the final one
//   nxt_val     value after the current step (final result when last=1)
//   nxt_v       V flag for that value (LSL sign change, else 0)
//   nxt_sticky  OR of all bits shifted out including the current step
module alu_iter_shift #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [1:0]       kind,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             zero_amt,
   output logic             last,
   output logic [WIDTH-1:0] nxt_val,
   output logic             nxt_v,
   output logic             nxt_sticky
);
   import alu_pkg::*;

   localparam int               SHW     = $clog2(WIDTH + 1);
   localparam logic [SHW-1:0]   CNT_MAX = SHW'(WIDTH);
   localparam logic [WIDTH-1:0] B_MAX   = WIDTH'(WIDTH);

   logic [WIDTH-1:0] val;
   logic [SHW-1:0]   cnt;
   logic [1:0]       knd;
   logic             sticky;
   logic             msb;
   logic             full;
   logic             out_bit;
   logic             keep_bit;

   always_comb begin
      out_bit  = val[0];
      nxt_val  = val >> 1;
      keep_bit = 1'b1;
      case (knd)
         SH_LSL: begin
            out_bit = val[WIDTH-1];
            nxt_val = val << 1;
         end
         SH_ASR: begin
            nxt_val  = {val[WIDTH-1], val[WIDTH-1:1]};
            // Only a full-width shift ever pushes the original sign bit out
            // on its final step; that bit must not reach the carry.
            keep_bit = !(full && (cnt == SHW'(1)));
         end
         default: ;
      endcase
      nxt_sticky = sticky | (out_bit & keep_bit);
      nxt_v      = (knd == SH_LSL) && (msb != nxt_val[WIDTH-1]);
   end

   assign last     = (cnt == SHW'(1));
   assign zero_amt = (b == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         val    <= '0;
         cnt    <= '0;
         knd    <= SH_LSL;
         sticky <= 1'b0;
         msb    <= 1'b0;
         full   <= 1'b0;
      end else if (load) begin
         val    <= a;
         knd    <= kind;
         sticky <= 1'b0;
         msb    <= a[WIDTH-1];
         full   <= (b >= B_MAX);
         cnt    <= (b >= B_MAX) ? CNT_MAX : b[SHW-1:0];
      end else if (step) begin
         val    <= nxt_val;
         sticky <= nxt_sticky;
         cnt    <= cnt - SHW'(1);
      end
   end

endmodule

// File: rtl/alu_iter.sv
// alu_iter: registered ALU with persistent {N,Z,V,C} flags, iterative shifts
// and ADC/SBC chaining through the stored carry.
// Optional feature: define ALU_ITER_MUL_EN to add an iterative unsigned
// shift-add multiplier (opcode 1011); without it 1011 is an invalid opcode.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  operation handshake (op, a, b)
//   op, a, b             opcode and operands (b = shift amount for shifts)
//   out_valid/out_ready  result handshake
//   result, flags, err   registered result, flag register, invalid-op marker
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE and out_valid only in DONE;
// result/flags/err hold stable while out_valid is high and out_ready is low.
module alu_iter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags,
   output logic             err
);
   import alu_pkg::*;

   state_t           state;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] dres;
   logic             dv, dc, dok, is_shift;
   logic             sh_load, sh_step, sh_zero, sh_last, sh_v, sh_c;
   logic [WIDTH-1:0] sh_val;
`ifdef ALU_ITER_MUL_EN
   logic             is_mul;
`endif

   // Single-cycle datapath, evaluated against the operands at accept time.
   // ADC/SBC read the carry from the flag register as it stands now.
   always_comb begin
      sum      = '0;
      dres     = '0;
      dv       = 1'b0;
      dc       = 1'b0;
      dok      = 1'b1;
      is_shift = 1'b0;
`ifdef ALU_ITER_MUL_EN
      is_mul   = 1'b0;
`endif
      case (op)
         OP_ADD, OP_ADC: begin
            sum  = {1'b0, a} + {1'b0, b}
                 + {{WIDTH{1'b0}}, (op == OP_ADC) & flags[FC]};
            dres = sum[WIDTH-1:0];
            dc   = sum[WIDTH];
            dv   = (a[WIDTH-1] == b[WIDTH-1]) && (dres[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB, OP_SBC: begin
            // Bit WIDTH of the difference is the borrow.
            sum  = {1'b0, a} - {1'b0, b}
                 - {{WIDTH{1'b0}}, (op == OP_SBC) & flags[FC]};
            dres = sum[WIDTH-1:0];
            dc   = sum[WIDTH];
            dv   = (a[WIDTH-1] != b[WIDTH-1]) && (dres[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: dres = a & b;
         OP_OR:  dres = a | b;
         OP_XOR: dres = a ^ b;
         OP_LSL, OP_LSR, OP_ASR: begin
            // A zero-length shift finishes at once with result=a, V=C=0.
            is_shift = 1'b1;
            dres     = a;
         end
`ifdef ALU_ITER_MUL_EN
         OP_MUL: is_mul = 1'b1;
`endif
         default: dok = 1'b0;
      endcase
   end

   assign sh_load = (state == S_IDLE) && in_valid && is_shift;

   alu_iter_shift #(.WIDTH(WIDTH)) u_shift (
      .clk        (clk),
      .rst        (rst),
      .load       (sh_load),
      .step       (sh_step),
      .kind       (op[1:0]),
      .a          (a),
      .b          (b),
      .zero_amt   (sh_zero),
      .last       (sh_last),
      .nxt_val    (sh_val),
      .nxt_v      (sh_v),
      .nxt_sticky (sh_c)
   );

`ifdef ALU_ITER_MUL_EN
   localparam int SHW = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] prod, mul_nxt;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH:0]     mul_sum;
   logic [SHW-1:0]     mul_cnt;
   logic               exec_mul, mul_last, mul_hi;

   // prod = {partial high half, remaining multiplier bits}; each step adds
   // the multiplicand into the high half when the current multiplier bit is
   // set, then shifts the whole register right by one.
   always_comb begin
      mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
      mul_nxt = {mul_sum, prod[WIDTH-1:1]};
   end

   assign mul_last = (mul_cnt == SHW'(1));
   assign mul_hi   = |mul_nxt[2*WIDTH-1:WIDTH];
   assign sh_step  = (state == S_EXEC) && !exec_mul;

   always_ff @(posedge clk) begin
      if (rst) begin
         prod     <= '0;
         mcand    <= '0;
         mul_cnt  <= '0;
         exec_mul <= 1'b0;
      end else if ((state == S_IDLE) && in_valid) begin
         exec_mul <= is_mul;
         prod     <= {{WIDTH{1'b0}}, b};
         mcand    <= a;
         mul_cnt  <= SHW'(WIDTH);
      end else if ((state == S_EXEC) && exec_mul) begin
         prod     <= mul_nxt;
         mul_cnt  <= mul_cnt - SHW'(1);
      end
   end
`else
   assign sh_step = (state == S_EXEC);
`endif

   // Control FSM; all handshake and result outputs are registered here and
   // the flag register is written only on entry to DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         result    <= '0;
         flags     <= 4'b0000;
         err       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  in_ready <= 1'b0;
                  if (is_shift && !sh_zero) begin
                     state <= S_EXEC;
                  end
`ifdef ALU_ITER_MUL_EN
                  else if (is_mul) begin
                     state <= S_EXEC;
                  end
`endif
                  else begin
                     state     <= S_DONE;
                     out_valid <= 1'b1;
                     err       <= !dok;
                     result    <= dres;
                     if (dok) flags <= {dres[WIDTH-1], (dres == '0), dv, dc};
                  end
               end
            end
            S_EXEC: begin
`ifdef ALU_ITER_MUL_EN
               if (exec_mul) begin
                  if (mul_last) begin
                     state     <= S_DONE;
                     out_valid <= 1'b1;
                     err       <= 1'b0;
                     result    <= mul_nxt[WIDTH-1:0];
                     flags     <= {mul_nxt[WIDTH-1], (mul_nxt[WIDTH-1:0] == '0),
                                   mul_hi, mul_hi};
                  end
               end else
`endif
               if (sh_last) begin
                  state     <= S_DONE;
                  out_valid <= 1'b1;
                  err       <= 1'b0;
                  result    <= sh_val;
                  flags     <= {sh_val[WIDTH-1], (sh_val == '0), sh_v, sh_c};
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state     <= S_IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed self-checking bench for alu_iter (WIDTH=8).
// Driver tasks issue operations and push the expected {err, flags, result}
// into exp_q; a monitor pops and compares on every output handshake.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
module tb_alu_iter;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op = 4'b0000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic         err;

  logic [W+4:0] exp_q[$];
  logic [W+4:0] exp_word;
  int           checks = 0;
  int           passes = 0;

  alu_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .err       (err)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'(out_valid), 32'(0));
      end else begin
        exp_word = exp_q.pop_front();
        chk("result", 32'(result), 32'(exp_word[W-1:0]));
        chk("flags",  32'(flags),  32'(exp_word[W+3:W]));
        chk("err",    32'(err),    32'(exp_word[W+4]));
      end
    end
  end

  // driver: issue one op, check latency, optional backpressure, handshake
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic [W-1:0] er, input logic [3:0] ef, input logic ee,
                        input int lat, input int hold);
    int n;
    @(posedge clk); #1;
    op = o; a = aa; b = bb; in_valid = 1'b1; out_ready = 1'b0;
    exp_q.push_back({ee, ef, er});
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 40);
    chk("latency", 32'(n), 32'(lat));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_result",   32'(result),    32'(er));
      chk("hold_flags",    32'(flags),     32'(ef));
      chk("hold_in_ready", 32'(in_ready),  32'(0));
      chk("hold_valid",    32'(out_valid), 32'(1));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("idle_after_handshake", 32'({out_valid, in_ready}), 32'(2'b01));
  endtask

  // driver: reset asserted while an LSL b=6 is in its second step
  task automatic reset_mid_op();
    @(posedge clk); #1;
    op = OP_LSL; a = 8'h0F; b = 8'd6; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("exec_in_ready", 32'(in_ready), 32'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_result",    32'(result),    32'(0));
    chk("rst_mid_flags",     32'(flags),     32'(0));
    chk("rst_mid_out_valid", 32'(out_valid), 32'(0));
    chk("rst_mid_in_ready",  32'(in_ready),  32'(1));
    repeat (8) @(negedge clk);
    chk("dropped_op_silent", 32'(out_valid), 32'(0));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_result",    32'(result),    32'(0));
    chk("reset_flags",     32'(flags),     32'(0));
    chk("reset_err",       32'(err),       32'(0));
    chk("reset_out_valid", 32'(out_valid), 32'(0));
    chk("reset_in_ready",  32'(in_ready),  32'(1));

    //      op      a      b      result flags    err   lat hold
    run_op(OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b1010, 1'b0, 1, 0);
    run_op(OP_SUB, 8'h00, 8'h01, 8'hFF, 4'b1001, 1'b0, 1, 0);
    run_op(OP_SBC, 8'h05, 8'h02, 8'h02, 4'b0000, 1'b0, 1, 0);
    run_op(OP_LSR, 8'h81, 8'h03, 8'h10, 4'b0001, 1'b0, 4, 5);
    run_op(OP_ADC, 8'h10, 8'h20, 8'h31, 4'b0000, 1'b0, 1, 0);
    run_op(OP_ASR, 8'h80, 8'h09, 8'hFF, 4'b1000, 1'b0, 9, 0);
    run_op(4'b0111, 8'h12, 8'h34, 8'h00, 4'b1000, 1'b1, 1, 2);
    run_op(OP_AND, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1'b0, 1, 0);
    run_op(OP_XOR, 8'hAA, 8'hAA, 8'h00, 4'b0100, 1'b0, 1, 0);
    run_op(OP_OR,  8'h80, 8'h01, 8'h81, 4'b1000, 1'b0, 1, 0);
    run_op(OP_LSL, 8'hC1, 8'h02, 8'h04, 4'b0011, 1'b0, 3, 0);
    run_op(OP_LSL, 8'h55, 8'h00, 8'h55, 4'b0000, 1'b0, 1, 0);
    run_op(OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b0101, 1'b0, 1, 0);
    run_op(OP_ASR, 8'h85, 8'h02, 8'hE1, 4'b1001, 1'b0, 3, 0);
    run_op(OP_LSR, 8'h0F, 8'h08, 8'h00, 4'b0101, 1'b0, 9, 0);
    run_op(OP_ASR, 8'h7F, 8'h08, 8'h00, 4'b0101, 1'b0, 9, 0);
`ifdef ALU_ITER_MUL_EN
    run_op(OP_MUL, 8'h10, 8'h10, 8'h00, 4'b0111, 1'b0, 9, 0);
`else
    run_op(OP_MUL, 8'h10, 8'h10, 8'h00, 4'b0101, 1'b1, 1, 0);
`endif

    reset_mid_op();

    run_op(OP_ADC, 8'h01, 8'h01, 8'h02, 4'b0000, 1'b0, 1, 0);
    run_op(OP_SUB, 8'h05, 8'h03, 8'h02, 4'b0000, 1'b0, 1, 0);

    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
